noise_scale_sequencer: RTL

Sequences the noise-generator datapath: reads noise samples from a sample BRAM, scales each by a Q8.24 gain, adds a DC offset and streams the results out over an AXI-Stream master with backpressure. It owns the BRAM address counter, the internal multiply/slice/add pipeline, a credit-limited output FIFO and the start/stop/loop control. It sits between the sample BRAM / AXI-Lite register bank and the channel-sounder transmit path.

---
 rtl/noise_pkg.sv | 16 +
 rtl/noise_scale_sequencer_if.sv | 25 ++
 rtl/nsq_fifo.sv | 52 +++++
 rtl/noise_scale_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared types and constants for the noise-scale sequencer: FSM states, pipeline
// latency and the Q8.24 product slice bounds.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int PIPE_LAT = 4;
  localparam int Q_FRAC   = 24;
  localparam int SLICE_LO = Q_FRAC;
  localparam int SLICE_HI = Q_FRAC + 31;

endpackage

// File: rtl/noise_scale_sequencer_if.sv
// BRAM read port plus AXI-Stream master of the noise-scale sequencer; the sequencer
// is the master side, the BRAM/stream sink is the slave side.
interface noise_scale_sequencer_if #(
  parameter int ADDR_W = 10
);

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_dout;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output bram_en, bram_addr, m_tdata, m_tvalid, m_tlast,
    input  bram_dout, m_tready
  );

  modport slave (
    input  bram_en, bram_addr, m_tdata, m_tvalid, m_tlast,
    output bram_dout, m_tready
  );

endinterface

// File: rtl/nsq_fifo.sv
// Synchronous first-word fall-through FIFO; the head word reads as zero while empty
// so the stream outputs are clean without resetting the storage array.
module nsq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/noise_scale_sequencer.sv
// Reads noise samples from BRAM, scales them by a Q8.24 gain, adds an offset and
// streams them out through a credit-limited FWFT FIFO under start/stop/loop control.
module noise_scale_sequencer
  import noise_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       scale,
  input  logic [31:0]       offset,
  output logic              busy,
  output logic              done,
  noise_scale_sequencer_if.master bus
);

  localparam int DATA_W  = 32;
  localparam int COEF_W  = 32;
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int SLICE_W = SLICE_HI - SLICE_LO + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W  = CNT_W + 1;
  localparam int INF_W   = $clog2(PIPE_LAT + 1);

  function automatic logic [DATA_W-1:0] slice_add(input logic signed [PROD_W-1:0] p,
                                                  input logic [DATA_W-1:0] o);
    return SLICE_W'(p >>> SLICE_LO) + o;
  endfunction

  function automatic logic [ADDR_W-1:0] eff_last(input logic [ADDR_W:0] n);
    return (n == '0) ? '0 : ADDR_W'(n - (ADDR_W+1)'(1));
  endfunction

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d, last_addr_q;
  logic                      loop_q;
  logic signed [COEF_W-1:0]  scale_q;
  logic [INF_W-1:0]          inflight_q, inflight_d;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W:0]           fifo_rd;
  logic [CRED_W-1:0]         credit_used;
  logic                      issue, at_last, launch;

  logic                      vld_p0, vld_p1, vld_p2, vld_p3;
  logic                      last_p0, last_p1, last_p2, last_p3;
  logic signed [DATA_W-1:0]  dout_p1;
  logic signed [PROD_W-1:0]  prod_p2;
  logic [DATA_W-1:0]         sum_p3;

  // Credits cover both FIFO occupancy and reads still travelling down the pipeline.
  assign credit_used = CRED_W'(fifo_count) + CRED_W'(inflight_q);
  assign issue       = (state_q == RUN) && !fifo_full && (credit_used < CRED_W'(FIFO_DEPTH));
  assign at_last     = (addr_q == last_addr_q);
  assign launch      = (state_q == IDLE) && start;
  assign fifo_pop    = !fifo_empty && bus.m_tready;

  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign bus.m_tvalid  = !fifo_empty;
  assign {bus.m_tlast, bus.m_tdata} = fifo_rd;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (issue) addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
        if (stop) state_d = DRAIN;
        else if (issue && at_last && !loop_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !vld_p3)      inflight_d = inflight_q + INF_W'(1);
    else if (!issue && vld_p3) inflight_d = inflight_q - INF_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      loop_q     <= 1'b0;
      inflight_q <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      if (launch) loop_q <= loop;
      vld_p0     <= issue;
      vld_p1     <= vld_p0;
      vld_p2     <= vld_p1;
      vld_p3     <= vld_p2;
    end
  end

  always_ff @(posedge CLK) begin
    if (launch) begin
      scale_q     <= $signed(scale);
      last_addr_q <= eff_last(len);
    end
    // p0: BRAM read in flight, last-address flag tagged to the read
    last_p0 <= at_last;
    // p1: BRAM output captured
    dout_p1 <= $signed(bus.bram_dout);
    last_p1 <= last_p0;
    // p2: full-width signed product
    prod_p2 <= dout_p1 * scale_q;
    last_p2 <= last_p1;
    // p3: Q8.24 slice plus live offset, written to the FIFO next
    sum_p3  <= slice_add(prod_p2, offset);
    last_p3 <= last_p2;
  end

  nsq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (vld_p3),
    .wr_data_i ({last_p3, sum_p3}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule
